// File: rtl/network_div_pkg.sv
// Shared types and constants for the sequential signed 30/16 divider.
// Pure declarations, no latency.
// No backpressure; consumed by the divider top, its step and its interface.
package network_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIN0_W = 30;
  localparam int DIN1_W = 16;
  localparam int DOUT_W = 15;
  localparam int PR_W   = DIN0_W + 1;
  localparam int ITER   = 30;
  localparam int CNT_W  = 5;

  localparam int SAT_POS_VAL = 16383;
  localparam int SAT_NEG_VAL = -16384;

  localparam logic [DOUT_W-1:0] SAT_POS = DOUT_W'(SAT_POS_VAL);
  localparam logic [DOUT_W-1:0] SAT_NEG = DOUT_W'(SAT_NEG_VAL);

endpackage

// File: rtl/network_div_seq_30s_16s_15_if.sv
// Operand/result handshake bundle for the sequential divider.
// No latency (wires only).
// in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface network_div_seq_30s_16s_15_if;
  import network_div_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DIN0_W-1:0] din0;
  logic [DIN1_W-1:0] din1;
  logic              out_valid;
  logic              out_ready;
  logic [DOUT_W-1:0] dout;
  logic [DIN1_W-1:0] rem;
  logic              ovf;
  logic              dz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, ovf, dz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, ovf, dz
  );

endinterface

// File: rtl/network_div_seq_30s_16s_15_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract if it fits.
// Combinational, zero latency.
// No backpressure; the caller decides when to register the result.
module network_div_seq_30s_16s_15_step
  import network_div_pkg::*;
(
  input  logic [PR_W-1:0]   pr,
  input  logic              dbit,
  input  logic [DIN1_W-1:0] dsr,
  output logic [PR_W-1:0]   pr_nxt,
  output logic              qbit
);

  logic [PR_W-1:0] shifted;
  logic [PR_W-1:0] dsr_ext;
  logic            unused_pr_msb;

  // The partial remainder is always below the divisor, so its MSB never carries data.
  assign unused_pr_msb = pr[PR_W-1];

  // Trial subtraction; keep the difference only when the divisor fits.
  always_comb begin
    shifted = {pr[PR_W-2:0], dbit};
    dsr_ext = {{(PR_W-DIN1_W){1'b0}}, dsr};
    qbit    = (shifted >= dsr_ext);
    pr_nxt  = qbit ? (shifted - dsr_ext) : shifted;
  end

endmodule

// File: rtl/network_div_seq_30s_16s_15.sv
// Sequential signed divider, 30-bit dividend / 16-bit divisor -> 15-bit saturated quotient + remainder.
// Latency: 32 edges counting the accept edge (2 for a zero divisor), plus one per ce-low cycle.
// Single operation in flight: in_ready only when idle; result held until out_ready with ce high.
module network_div_seq_30s_16s_15
  import network_div_pkg::*;
#(
  parameter [31:0] ID         = 32'd1,
  parameter [31:0] NUM_STAGE  = 32'd32,
  parameter [31:0] din0_WIDTH = 32'd30,
  parameter [31:0] din1_WIDTH = 32'd16,
  parameter [31:0] dout_WIDTH = 32'd15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  network_div_seq_30s_16s_15_if.slave    bus
);

  // Instance/documentation parameters; the datapath widths are fixed by the package.
  localparam logic [31:0] unused_params = ID ^ NUM_STAGE ^ din0_WIDTH ^ din1_WIDTH ^ dout_WIDTH;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DIN0_W-1:0] dvd_q;
  logic [DIN1_W-1:0] dsr_q;
  logic [DIN0_W-1:0] quo_q;
  logic [PR_W-1:0]   pr_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic [DOUT_W-1:0] dout_q;
  logic [DIN1_W-1:0] rem_q;
  logic              ovf_q;
  logic              dz_q;

  logic [DIN0_W-1:0] a_mag;
  logic [DIN1_W-1:0] b_mag;
  logic [PR_W-1:0]   step_pr;
  logic              step_q;
  logic [DOUT_W-1:0] fix_dout;
  logic [DIN1_W-1:0] fix_rem;
  logic              fix_ovf;

  // Magnitudes fit unsigned even for the most-negative operands.
  assign a_mag = bus.din0[DIN0_W-1] ? (-bus.din0) : bus.din0;
  assign b_mag = bus.din1[DIN1_W-1] ? (-bus.din1) : bus.din1;

  network_div_seq_30s_16s_15_step u_step (
    .pr     (pr_q),
    .dbit   (dvd_q[DIN0_W-1]),
    .dsr    (dsr_q),
    .pr_nxt (step_pr),
    .qbit   (step_q)
  );

  // State register; ce low freezes the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else if (ce) state_q <= state_d;
  end

  // Next-state: zero divisor skips the iterations, DONE waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = (b_mag == '0) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign application and saturation of the magnitude quotient/remainder.
  always_comb begin
    fix_dout = '0;
    fix_rem  = '0;
    fix_ovf  = 1'b0;
    if (dsr_q == '0) begin
      fix_ovf  = 1'b1;
      fix_dout = neg_r_q ? SAT_NEG : SAT_POS;
    end else if (neg_q_q) begin
      if (quo_q > DIN0_W'(-SAT_NEG_VAL)) begin
        fix_ovf  = 1'b1;
        fix_dout = SAT_NEG;
      end else begin
        fix_dout = -quo_q[DOUT_W-1:0];
        fix_rem  = neg_r_q ? (-pr_q[DIN1_W-1:0]) : pr_q[DIN1_W-1:0];
      end
    end else begin
      if (quo_q > DIN0_W'(SAT_POS_VAL)) begin
        fix_ovf  = 1'b1;
        fix_dout = SAT_POS;
      end else begin
        fix_dout = quo_q[DOUT_W-1:0];
        fix_rem  = neg_r_q ? (-pr_q[DIN1_W-1:0]) : pr_q[DIN1_W-1:0];
      end
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, register results in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      pr_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          dvd_q   <= a_mag;
          dsr_q   <= b_mag;
          neg_r_q <= bus.din0[DIN0_W-1];
          neg_q_q <= bus.din0[DIN0_W-1] ^ bus.din1[DIN1_W-1];
          cnt_q   <= '0;
          pr_q    <= '0;
          quo_q   <= '0;
        end
        S_CALC: begin
          dvd_q <= {dvd_q[DIN0_W-2:0], 1'b0};
          pr_q  <= step_pr;
          quo_q <= {quo_q[DIN0_W-2:0], step_q};
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          dout_q <= fix_dout;
          rem_q  <= fix_rem;
          ovf_q  <= fix_ovf;
          dz_q   <= (dsr_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.dout      = dout_q;
  assign bus.rem       = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule
